// File: rtl/mem_wb_pipe_stage_pkg.sv
// mem_wb_pipe_stage_pkg: shared pipeline-stage constants, control bit indices and occupancy encoding
package mem_wb_pipe_stage_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF = 5;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;
endpackage

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: generic two-entry valid/ready skid buffer with flush and occupancy
module pipe_skid_buffer
  import mem_wb_pipe_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);
  occ_e         r_state;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_in_fire;
  logic         w_out_fire;
  // in_ready never looks at out_ready, so upstream sees no combinational backpressure path
  assign in_ready   = (r_state != TWO) & ~flush & ~reset;
  assign out_valid  = (r_state != EMPTY);
  assign out_data   = r_main;
  assign occupancy  = r_state;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_in_fire) begin
          r_state <= ONE;
          r_main  <= in_data;
        end
        ONE: if (w_in_fire && w_out_fire) begin
          r_main <= in_data;
        end else if (w_in_fire) begin
          r_state <= TWO;
          r_skid  <= in_data;
        end else if (w_out_fire) begin
          r_state <= EMPTY;
        end
        TWO: if (w_out_fire) begin
          r_state <= ONE;
          r_main  <= r_skid;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: MEM->WB stage register with skid-buffered flow control and bubble-gated control
module mem_wb_pipe_stage
  import mem_wb_pipe_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = 2,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
);
  localparam int P = CTRL_W + 2 * DATA_W + RD_W;
  logic [P-1:0]      w_in;
  logic [P-1:0]      w_out;
  logic [CTRL_W-1:0] w_ctrl;
  assign w_in = {in_ctrl, in_mem_data, in_alu_out, in_rd};
  pipe_skid_buffer #(.W(P)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out),
    .occupancy (occupancy)
  );
  assign {w_ctrl, out_mem_data, out_alu_out, out_rd} = w_out;
  // flushed payload stays in the register, so empty slots must still read as a bubble
  assign out_ctrl = out_valid ? w_ctrl : '0;
endmodule
